// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder
//   Assembles bytes from the UART receiver into command frames, drives the
//   register file (write/read) and ALU strobes, and pushes response bytes
//   (read data or 2-byte ALU result, low byte first) into the TX FIFO.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   RX_P_DATA/RX_D_VLD  received byte + one-cycle valid
//   PAR_ERR/STP_ERR     error flags qualifying the byte on RX_D_VLD
//   RdData/RdData_Valid register-file read return
//   ALU_OUT/ALU_OUT_VLD ALU result return
//   FIFO_FULL           TX FIFO back-pressure
//   Address/WrEn/RdEn/WrData   register-file request (strobes one cycle)
//   ALU_EN/ALU_FUN/CLK_GATE_EN ALU start, function, clock-gate enable
//   WR_DATA/WR_INC      TX FIFO push
module uart_cmd_decoder #(
    parameter int width   = 8,
    parameter int addr_w  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [width-1:0]     RX_P_DATA,
    input  logic                 RX_D_VLD,
    input  logic                 PAR_ERR,
    input  logic                 STP_ERR,
    input  logic [width-1:0]     RdData,
    input  logic                 RdData_Valid,
    input  logic [2*width-1:0]   ALU_OUT,
    input  logic                 ALU_OUT_VLD,
    input  logic                 FIFO_FULL,
    output logic [addr_w-1:0]    Address,
    output logic                 WrEn,
    output logic                 RdEn,
    output logic [width-1:0]     WrData,
    output logic                 ALU_EN,
    output logic [3:0]           ALU_FUN,
    output logic                 CLK_GATE_EN,
    output logic [width-1:0]     WR_DATA,
    output logic                 WR_INC
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [width-1:0] CMD_WR     = width'(8'hAA);
    localparam logic [width-1:0] CMD_RD     = width'(8'hBB);
    localparam logic [width-1:0] CMD_ALU_OP = width'(8'hCC);
    localparam logic [width-1:0] CMD_ALU_NP = width'(8'hDD);

    // ST_ prefix keeps the state names clear of the WR_DATA port.
    typedef enum logic [3:0] {
        ST_IDLE, ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR, ST_RD_WAIT,
        ST_OP_A, ST_OP_B, ST_ALU_FUN_S, ST_ALU_WAIT, ST_SEND_LO, ST_SEND_HI
    } state_t;

    state_t               state;
    logic [addr_w-1:0]    addr_r;     // write address held between addr and data bytes
    logic [2*width-1:0]   resp;       // latched response (read data zero-extended)
    logic                 resp_two;   // response has a high byte (ALU result)
    logic [CNT_W-1:0]     cnt;

    logic byte_ok, byte_bad, timed_out;
    assign byte_ok   = RX_D_VLD && !PAR_ERR && !STP_ERR;
    assign byte_bad  = RX_D_VLD && (PAR_ERR || STP_ERR);
    assign timed_out = (cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            addr_r      <= '0;
            resp        <= '0;
            resp_two    <= 1'b0;
            cnt         <= '0;
            Address     <= '0;
            WrEn        <= 1'b0;
            RdEn        <= 1'b0;
            WrData      <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
            WR_DATA     <= '0;
            WR_INC      <= 1'b0;
        end else begin
            WrEn   <= 1'b0;
            RdEn   <= 1'b0;
            ALU_EN <= 1'b0;
            WR_INC <= 1'b0;

            // Errored bytes abort a frame that is still being assembled.
            // Once a frame is complete (wait/send states) every incoming
            // byte, good or bad, is simply dropped.
            case (state)
                ST_IDLE: begin
                    if (byte_ok) begin
                        case (RX_P_DATA)
                            CMD_WR:     state <= ST_WR_ADDR;
                            CMD_RD:     state <= ST_RD_ADDR;
                            CMD_ALU_OP: state <= ST_OP_A;
                            CMD_ALU_NP: begin
                                state       <= ST_ALU_FUN_S;
                                CLK_GATE_EN <= 1'b1;
                            end
                            default:    state <= ST_IDLE;
                        endcase
                    end
                end

                ST_WR_ADDR: begin
                    if (byte_bad) state <= ST_IDLE;
                    else if (byte_ok) begin
                        addr_r <= RX_P_DATA[addr_w-1:0];
                        state  <= ST_WR_DATA;
                    end
                end

                ST_WR_DATA: begin
                    if (byte_bad) state <= ST_IDLE;
                    else if (byte_ok) begin
                        Address <= addr_r;
                        WrData  <= RX_P_DATA;
                        WrEn    <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end

                ST_RD_ADDR: begin
                    if (byte_bad) state <= ST_IDLE;
                    else if (byte_ok) begin
                        Address <= RX_P_DATA[addr_w-1:0];
                        RdEn    <= 1'b1;
                        cnt     <= '0;
                        state   <= ST_RD_WAIT;
                    end
                end

                ST_RD_WAIT: begin
                    // valid beats a coincident timeout
                    if (RdData_Valid) begin
                        resp     <= {{width{1'b0}}, RdData};
                        resp_two <= 1'b0;
                        state    <= ST_SEND_LO;
                    end else if (timed_out) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_OP_A: begin
                    if (byte_bad) state <= ST_IDLE;
                    else if (byte_ok) begin
                        Address <= '0;
                        WrData  <= RX_P_DATA;
                        WrEn    <= 1'b1;
                        state   <= ST_OP_B;
                    end
                end

                ST_OP_B: begin
                    if (byte_bad) state <= ST_IDLE;
                    else if (byte_ok) begin
                        Address     <= addr_w'(1);
                        WrData      <= RX_P_DATA;
                        WrEn        <= 1'b1;
                        CLK_GATE_EN <= 1'b1;
                        state       <= ST_ALU_FUN_S;
                    end
                end

                ST_ALU_FUN_S: begin
                    if (byte_bad) begin
                        CLK_GATE_EN <= 1'b0;
                        state       <= ST_IDLE;
                    end else if (byte_ok) begin
                        ALU_EN  <= 1'b1;
                        ALU_FUN <= RX_P_DATA[3:0];
                        cnt     <= '0;
                        state   <= ST_ALU_WAIT;
                    end
                end

                ST_ALU_WAIT: begin
                    if (ALU_OUT_VLD) begin
                        resp        <= ALU_OUT;
                        resp_two    <= 1'b1;
                        CLK_GATE_EN <= 1'b0;
                        state       <= ST_SEND_LO;
                    end else if (timed_out) begin
                        CLK_GATE_EN <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_SEND_LO: begin
                    if (!FIFO_FULL) begin
                        WR_DATA <= resp[width-1:0];
                        WR_INC  <= 1'b1;
                        state   <= resp_two ? ST_SEND_HI : ST_IDLE;
                    end
                end

                ST_SEND_HI: begin
                    if (!FIFO_FULL) begin
                        WR_DATA <= resp[2*width-1:width];
                        WR_INC  <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
